// File: rtl/rx_irq_moderator.sv
// Rx MSI moderator: one outstanding MSI at a time, programmable quiet gap after host ack.
// Optional ack watchdog/reissue enabled by defining RX_IRQ_RETRY_EN.
module rx_irq_moderator #(
   parameter int           HOLDOFF_CYCLES = 250,
   parameter int           TIMER_W        = 24,
   parameter logic [7:0]   MSI_VECTOR     = 8'h00,
   parameter int           RETRY_CYCLES   = 2500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        send_irq,
   input  logic        irq_en,
   input  logic        irq_ack,
   input  logic        cfg_interrupt_msienable,
   input  logic        cfg_interrupt_rdy_n,
   output logic        cfg_interrupt_n,
   output logic        cfg_interrupt_assert_n,
   output logic [7:0]  cfg_interrupt_di,
   output logic [31:0] irq_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_ACK = 2'd2,
      HOLDOFF  = 2'd3
   } state_t;

   localparam logic [TIMER_W-1:0] HOLDOFF_LOAD = TIMER_W'(HOLDOFF_CYCLES);
   localparam logic [TIMER_W-1:0] RETRY_LOAD   = TIMER_W'(RETRY_CYCLES);

   state_t             state_reg, state_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic               accept;
   logic               irq_n_reg;
   logic               assert_n_reg;
   logic [7:0]         di_reg;
   logic [31:0]        count_reg;

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (send_irq && irq_en && cfg_interrupt_msienable)
               state_next = REQ;
         end
         REQ: begin
            // Once raised, the request must stay up until the endpoint takes it.
            if (!cfg_interrupt_rdy_n) begin
               state_next = WAIT_ACK;
               accept     = 1'b1;
`ifdef RX_IRQ_RETRY_EN
               timer_next = RETRY_LOAD;
`endif
            end
         end
         WAIT_ACK: begin
            if (irq_ack) begin
               if (HOLDOFF_CYCLES == 0) begin
                  state_next = IDLE;
                  timer_next = '0;
               end else begin
                  state_next = HOLDOFF;
                  timer_next = HOLDOFF_LOAD;
               end
            end
`ifdef RX_IRQ_RETRY_EN
            else if (timer_reg == '0) begin
               state_next = send_irq ? REQ : IDLE;
            end else begin
               timer_next = timer_reg - 1'b1;
            end
`endif
         end
         HOLDOFF: begin
            if (timer_reg <= TIMER_W'(1)) begin
               state_next = IDLE;
               timer_next = '0;
            end else begin
               timer_next = timer_reg - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         timer_reg    <= '0;
         irq_n_reg    <= 1'b1;
         assert_n_reg <= 1'b1;
         di_reg       <= MSI_VECTOR;
         count_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         irq_n_reg    <= (state_next != REQ);
         assert_n_reg <= 1'b1;
         di_reg       <= MSI_VECTOR;
         if (accept)
            count_reg <= count_reg + 32'd1;
      end
   end

`ifndef RX_IRQ_RETRY_EN
   // Watchdog period is only meaningful with the retry build.
   logic retry_unused;
   assign retry_unused = ^RETRY_LOAD;
`endif

   assign cfg_interrupt_n        = irq_n_reg;
   assign cfg_interrupt_assert_n = assert_n_reg;
   assign cfg_interrupt_di       = di_reg;
   assign irq_count              = count_reg;

endmodule

// File: tb/tb_rx_irq_moderator.sv
// Scoreboard bench for rx_irq_moderator: expected MSI requests are queued by the stimulus
// and matched by a monitor on every cfg_interrupt_n fall/rise.
module tb_rx_irq_moderator;

   localparam logic [7:0] VEC = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        send_irq = 1'b0;
   logic        irq_en = 1'b0;
   logic        irq_ack = 1'b0;
   logic        msienable = 1'b0;
   logic        rdy_n = 1'b1;
   logic        cfg_interrupt_n;
   logic        cfg_interrupt_assert_n;
   logic [7:0]  cfg_interrupt_di;
   logic [31:0] irq_count;

   rx_irq_moderator #(
      .HOLDOFF_CYCLES (8),
      .TIMER_W        (24),
      .MSI_VECTOR     (VEC),
      .RETRY_CYCLES   (50)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .send_irq                (send_irq),
      .irq_en                  (irq_en),
      .irq_ack                 (irq_ack),
      .cfg_interrupt_msienable (msienable),
      .cfg_interrupt_rdy_n     (rdy_n),
      .cfg_interrupt_n         (cfg_interrupt_n),
      .cfg_interrupt_assert_n  (cfg_interrupt_assert_n),
      .cfg_interrupt_di        (cfg_interrupt_di),
      .irq_count               (irq_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string name;
      int    fall;
      int    rise;
      int    count;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) tick();
   endtask

   task automatic expect_req(input string name, input int fall, input int rise, input int count);
      exp_t e;
      e.name = name; e.fall = fall; e.rise = rise; e.count = count;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per request and checks its timing and resulting count.
   logic prev_n = 1'b1;
   logic have_cur = 1'b0;
   exp_t cur;
   always @(negedge clk) begin
      chk("const_di", cfg_interrupt_di, VEC);
      chk("const_assert_n", cfg_interrupt_assert_n, 1);
      if (prev_n && !cfg_interrupt_n) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_req @cyc %0d: got request, required none", cyc);
         end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk({cur.name, "_fall_cycle"}, cyc, cur.fall);
         end
      end
      if (!prev_n && cfg_interrupt_n && have_cur) begin
         chk({cur.name, "_rise_cycle"}, cyc, cur.rise);
         chk({cur.name, "_irq_count"}, irq_count, cur.count);
         have_cur = 1'b0;
      end
      prev_n = cfg_interrupt_n;
   end

   initial begin
      wait_until(2);
      chk("reset_irq_n", cfg_interrupt_n, 1);
      chk("reset_count", irq_count, 0);
      rst = 1'b0;
      irq_en = 1'b1;
      msienable = 1'b1;

      // Basic MSI
      wait_until(10);
      expect_req("basic", 11, 15, 1);
      send_irq = 1'b1;
      wait_until(14); rdy_n = 1'b0;
      wait_until(15); rdy_n = 1'b1;
      wait_until(29);
      chk("no_second_req_n", cfg_interrupt_n, 1);
      chk("no_second_req_count", irq_count, 1);

      // Holdoff of 8 cycles with send_irq held high
      wait_until(30);
      expect_req("holdoff", 40, 43, 2);
      irq_ack = 1'b1;
      wait_until(31); irq_ack = 1'b0;
      wait_until(42); rdy_n = 1'b0;
      wait_until(43); rdy_n = 1'b1; send_irq = 1'b0;
      wait_until(45); irq_ack = 1'b1;
      wait_until(46); irq_ack = 1'b0;

      // Withdrawal attempt; ack coincident with rdy must be ignored
      wait_until(60);
      expect_req("withdraw", 61, 81, 3);
      send_irq = 1'b1;
      wait_until(61); send_irq = 1'b0;
      wait_until(62); irq_en = 1'b0;
      wait_until(70); irq_en = 1'b1;
      wait_until(80); rdy_n = 1'b0; irq_ack = 1'b1;
      wait_until(81); rdy_n = 1'b1; irq_ack = 1'b0; send_irq = 1'b1;
      wait_until(96); irq_en = 1'b0;
      wait_until(97); irq_ack = 1'b1;
      wait_until(98); irq_ack = 1'b0;

      // Gating: irq_en then msienable low with send_irq high
      wait_until(110); irq_en = 1'b1; msienable = 1'b0;
      wait_until(160); irq_en = 1'b0; msienable = 1'b1;
      wait_until(209);
      chk("gated_irq_n", cfg_interrupt_n, 1);
      chk("gated_count", irq_count, 3);
      wait_until(210);
      expect_req("ungate_reset", 211, 214, 0);
      irq_en = 1'b1;

      // Reset on the third REQ cycle
      wait_until(213); rst = 1'b1;
      wait_until(214);
      chk("midreq_rst_irq_n", cfg_interrupt_n, 1);
      chk("midreq_rst_count", irq_count, 0);
      wait_until(215);
      expect_req("post_reset", 216, 221, 1);
      rst = 1'b0;
      wait_until(220); rdy_n = 1'b0;
      wait_until(221); rdy_n = 1'b1; send_irq = 1'b0;
      wait_until(222);
      chk("post_reset_count", irq_count, 1);
      send_irq = 1'b1;

`ifdef RX_IRQ_RETRY_EN
      expect_req("retry", 272, 276, 2);
      wait_until(275); rdy_n = 1'b0;
      wait_until(276); rdy_n = 1'b1; send_irq = 1'b0;
      wait_until(340);
      chk("retry_idle_irq_n", cfg_interrupt_n, 1);
      chk("retry_idle_count", irq_count, 2);
      expect_req("after_retry_idle", 341, 344, 3);
      send_irq = 1'b1;
      wait_until(343); rdy_n = 1'b0;
      wait_until(344); rdy_n = 1'b1; send_irq = 1'b0;
`else
      wait_until(340);
      chk("wait_ack_hold_irq_n", cfg_interrupt_n, 1);
      chk("wait_ack_hold_count", irq_count, 1);
`endif
      wait_until(350);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
